mdu_divider: RTL and testbench
==============================

Name: mdu_divider

Overview:
- Multi-cycle iterative divider; the inverse of the single-cycle multiply path in the mMIPS datapath.
- Implements MIPS DIV/DIVU semantics with a start/busy/done handshake.
- Quotient goes to LO and remainder to HI.
- Sits beside the ALU in the execute stage. The controller stalls on busy and latches hi/lo on done.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; hi/lo/div_by_zero valid from this cycle on.
- lo  out  WIDTH  quotient.
- hi  out  WIDTH  remainder.
- div_by_zero  out  1  set with done when b == 0.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, lo=0, hi=0, div_by_zero=0, state=IDLE, counter=0.
- States:
  - IDLE: start=1 in cycle k captures a, b and is_signed. It loads the operand magnitudes (two's-complement abs if is_signed), records the quotient sign (sign(a)^sign(b)) and the remainder sign (sign(a)), clears the partial remainder and counter, then goes to RUN. busy=1 from cycle k+1.
  - RUN: one restoring step per cycle: shift {rem,quot} left 1; if rem >= |b| then subtract and set quotient LSB. The counter increments each cycle. After WIDTH steps (cycles k+1..k+WIDTH) go to FIX.
  - FIX (cycle k+WIDTH+1): apply the signs, write lo/hi, update div_by_zero, go to IDLE. done=1 and busy=0 in cycle k+WIDTH+2.
- Fixed latency is WIDTH+2 cycles from start to done (34 for WIDTH=32). This includes divide-by-zero.
- Arithmetic:
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - The invariant a == q*b + r holds mod 2^WIDTH.
  - 0x80000000 / -1 signed gives lo=0x80000000, hi=0. This falls out of the magnitude path; there is no trap.
- Divide by zero: lo=all ones, hi=a (original, unmodified), div_by_zero=1. Same latency as a normal divide.
- Output hold: lo/hi/div_by_zero hold until the next FIX or reset. done is a single-cycle pulse.
- Boundary conditions:
  - start while busy: ignored. No queuing, and no effect on the current operation.
  - a/b/is_signed changing while busy: ignored, because the operands are captured at start.
  - start in the done cycle: accepted, since the block is already in IDLE. The old lo/hi stay visible until the new FIX.
  - rst mid-operation: next cycle is IDLE with all outputs at their reset values. No done pulse for the aborted operation.
  - rst and start in the same cycle: reset wins; start is dropped.

Decomposition:
- Shared include file mdu_defs.vh holds:
  - state encodings (IDLE, RUN, FIX);
  - DIV_LATENCY = WIDTH+2;
  - the DIV_BY_ZERO_LO constant (all ones).
- One combinational sub-module, div_step: takes partial remainder, quotient and divisor magnitude; returns the next partial remainder and next quotient. The FSM and registers stay in mdu_divider.

Test Plan:
1. DIVU a=100, b=7 -> done exactly 34 cycles after start; lo=14, hi=2, div_by_zero=0. busy high for cycles 1..33 only.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
3. a=0x80000000, b=0xFFFFFFFF: DIV -> lo=0x80000000, hi=0; DIVU -> lo=0, hi=0x80000000.
4. a=0x00001234, b=0 (either signedness) -> 34-cycle latency; lo=0xFFFFFFFF, hi=0x00001234, div_by_zero=1. A following 10/3 clears div_by_zero, giving lo=3, hi=1.
5. Handshake:
   - Start 9/2, pulse start again at cycle 5 with 50/5 -> only 9/2 completes (lo=4, hi=1).
   - Then start 50/5 in the done cycle -> lo/hi hold 4/1 until the second done, which gives lo=10, hi=0.
6. Assert rst at cycle 10 of a 1000/3 operation -> next cycle busy=0, done=0, lo=hi=0, no done pulse. A fresh 1000/3 then gives lo=333, hi=1.

Source files
------------

// File: rtl/mdu_divider_pkg.sv
// Shared definitions for the iterative MDU divider: FSM encoding, default widths
// and the fixed start-to-done latency.
package mdu_divider_pkg;

    localparam int unsigned MDU_WIDTH   = 32;
    localparam int unsigned MDU_CNT_W   = 6;
    localparam int unsigned DIV_LATENCY = MDU_WIDTH + 2;

    // Quotient reported for a zero divisor (all ones at the default width).
    localparam logic [MDU_WIDTH-1:0] DIV_BY_ZERO_LO = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

    // Start-to-done latency for an arbitrary operand width.
    function automatic int unsigned div_latency(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mdu_divider_div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quot} left,
// subtract the divisor when it fits and shift the result bit into the quotient.
module mdu_divider_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic [WIDTH-1:0] quot_next_c
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] divisor_ext;
    logic           fits;

    // One extra bit: the shifted remainder can exceed 2^WIDTH for large divisors.
    always_comb begin
        shifted     = {rem, quot[WIDTH-1]};
        divisor_ext = {1'b0, divisor};
        fits        = (shifted >= divisor_ext);
        rem_next_c  = WIDTH'(fits ? (shifted - divisor_ext) : shifted);
        quot_next_c = {quot[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mdu_divider.sv
// Multi-cycle DIV/DIVU unit: quotient to lo, remainder to hi, start/busy/done
// handshake with a fixed WIDTH+2 cycle latency including divide-by-zero.
module mdu_divider
    import mdu_divider_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic             busy_d, done_d, dbz_d;
    logic [WIDTH-1:0] lo_d, hi_d;
    logic [WIDTH-1:0] step_rem_c, step_quot_c;

    mdu_divider_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem        (rem_q),
        .quot       (quot_q),
        .divisor    (dvsr_q),
        .rem_next_c (step_rem_c),
        .quot_next_c(step_quot_c)
    );

    // Next-state and datapath control; operands are only captured in IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        a_d        = a_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        busy_d     = busy;
        done_d     = 1'b0;
        lo_d       = lo;
        hi_d       = hi;
        dbz_d      = div_by_zero;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d        = a;
                    quot_d     = (is_signed && a[WIDTH-1]) ? -a : a;
                    dvsr_d     = (is_signed && b[WIDTH-1]) ? -b : b;
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_quot_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d  = is_signed && a[WIDTH-1];
                    zero_d     = (b == '0);
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                rem_d  = step_rem_c;
                quot_d = step_quot_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Zero divisor overrides the magnitude result; hi returns the raw dividend.
                if (zero_q) begin
                    lo_d  = '1;
                    hi_d  = a_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d  = neg_quot_q ? -quot_q : quot_q;
                    hi_d  = neg_rem_q ? -rem_q : rem_q;
                    dbz_d = 1'b0;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            dvsr_q      <= '0;
            a_q         <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lo          <= '0;
            hi          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            dvsr_q      <= dvsr_d;
            a_q         <= a_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            zero_q      <= zero_d;
            busy        <= busy_d;
            done        <= done_d;
            lo          <= lo_d;
            hi          <= hi_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: directed handshake/boundary steps plus
// random DIV/DIVU operations compared against a plain-arithmetic reference.
module tb_mdu_divider;
    import mdu_divider_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    mdu_divider #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .lo         (lo),
        .hi         (hi),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic gives truncating division with dividend-signed remainder.
    function automatic void model(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        if (bv == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = av;
            z = 1'b1;
        end else if (sgn) begin
            sa = $signed(av);
            sb = $signed(bv);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            z  = 1'b0;
        end else begin
            ua = longint'({32'd0, av});
            ub = longint'({32'd0, bv});
            q  = 32'(ua / ub);
            r  = 32'(ua % ub);
            z  = 1'b0;
        end
    endfunction

    // Issue one operation from the current cycle and follow it to done.
    // Operands are scrambled while busy; glitch_at re-pulses start with 50/5.
    task automatic run_op(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                          input int glitch_at, output int lat, output int busy_cycles,
                          output bit hold_ok, output bit early_ok);
        logic [31:0] lo0;
        logic [31:0] hi0;
        lo0 = lo;
        hi0 = hi;
        lat = 0;
        busy_cycles = 0;
        hold_ok = 1'b1;
        early_ok = 1'b1;
        is_signed = sgn;
        a = av;
        b = bv;
        start = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            a = $urandom;
            b = $urandom;
            is_signed = 1'($urandom);
            if (n == glitch_at) begin
                start = 1'b1;
                a = 32'd50;
                b = 32'd5;
            end
            if (n == 1 && (busy !== 1'b1 || done !== 1'b0)) early_ok = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            if (lo !== lo0 || hi !== hi0) hold_ok = 1'b0;
        end
    endtask

    task automatic do_op(input string tag, input logic sgn, input logic [31:0] av,
                         input logic [31:0] bv, input int glitch_at);
        int lat;
        int bc;
        bit hold_ok;
        bit early_ok;
        logic [31:0] q;
        logic [31:0] r;
        logic z;
        model(sgn, av, bv, q, r, z);
        run_op(sgn, av, bv, glitch_at, lat, bc, hold_ok, early_ok);
        check({tag, "_lat"}, lat, DIV_LATENCY);
        check({tag, "_lo"}, lo, q);
        check({tag, "_hi"}, hi, r);
        check({tag, "_dbz"}, div_by_zero, z);
        check({tag, "_busy_cycles"}, bc, DIV_LATENCY - 1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_hold"}, hold_ok, 1'b1);
        check({tag, "_first_cycle"}, early_ok, 1'b1);
    endtask

    initial begin
        int lat;
        int bc;
        bit hold_ok;
        bit early_ok;
        bit saw_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic rs;

        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_lo", lo, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_dbz", div_by_zero, 1'b0);

        // Reset and start together: start must be dropped.
        start = 1'b1;
        a = 32'd10;
        b = 32'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("rst_start_idle", busy, 1'b0);

        // Basic DIVU with exact latency and busy window.
        do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
        check("divu_100_7_lo_const", lo, 32'd14);
        check("divu_100_7_hi_const", hi, 32'd2);
        @(posedge clk);
        #1;
        check("done_single_pulse", done, 1'b0);

        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        check("div_7_m2_lo_const", lo, 32'hFFFF_FFFD);
        check("div_7_m2_hi_const", hi, 32'd1);

        do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_min_m1_lo_const", lo, 32'h8000_0000);
        check("div_min_m1_hi_const", hi, 32'd0);
        do_op("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("divu_min_max_lo_const", lo, 32'd0);
        check("divu_min_max_hi_const", hi, 32'h8000_0000);

        do_op("dbz_u", 1'b0, 32'h0000_1234, 32'd0, 0);
        check("dbz_u_lo_const", lo, 32'hFFFF_FFFF);
        check("dbz_u_hi_const", hi, 32'h0000_1234);
        check("dbz_u_flag_const", div_by_zero, 1'b1);
        do_op("dbz_s", 1'b1, 32'h0000_1234, 32'd0, 0);
        do_op("dbz_s_neg", 1'b1, 32'h8000_0001, 32'd0, 0);
        do_op("after_dbz", 1'b0, 32'd10, 32'd3, 0);
        check("after_dbz_flag_const", div_by_zero, 1'b0);

        // Start while busy is ignored; a start in the done cycle is accepted.
        @(posedge clk);
        #1;
        do_op("hs_9_2", 1'b0, 32'd9, 32'd2, 5);
        check("hs_9_2_lo_const", lo, 32'd4);
        check("hs_9_2_hi_const", hi, 32'd1);
        do_op("hs_50_5", 1'b0, 32'd50, 32'd5, 0);
        check("hs_50_5_lo_const", lo, 32'd10);
        check("hs_50_5_hi_const", hi, 32'd0);

        // Reset in the middle of an operation.
        is_signed = 1'b0;
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_dbz", div_by_zero, 1'b0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 1'b0);
        do_op("fresh_1000_3", 1'b0, 32'd1000, 32'd3, 0);
        check("fresh_1000_3_lo_const", lo, 32'd333);
        check("fresh_1000_3_hi_const", hi, 32'd1);

        // Random operations with a mix of operand classes.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 16));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                3: rb = $urandom >> $urandom_range(0, 31);
                4: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            do_op($sformatf("rand%0d", i), rs, ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
